// File: rtl/decoder_hold.sv
// Binary-to-one-hot decoder with a programmable hold window per accepted code.
// The decoded line is held for HOLD enabled cycles; when it drops, done pulses once.
module decoder_hold #(
   parameter int IN_LEN = 2,
   parameter int HOLD   = 4,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [IN_LEN-1:0]      code,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [(1<<IN_LEN)-1:0] y,
   output logic                   y_valid,
   output logic                   done,
   output logic                   o_dbg_state
);

   localparam int OUT_W = 1 << IN_LEN;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [OUT_W-1:0] r_y;
   logic             r_y_valid;
   logic             r_done;

   logic             w_last;
   logic             w_ready;
   logic             w_accept;

   // Handshake: a code transfers on a rising edge where in_valid and in_ready are
   // both high. in_ready depends only on en, rst and state (never on in_valid).
   // in_valid is ignored whenever in_ready is low.
   assign w_last   = (r_state == S_HOLD) && (r_cnt == '0);
   assign w_ready  = !rst && en && ((r_state == S_IDLE) || w_last);
   assign w_accept = in_valid && w_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_y       <= '0;
         r_y_valid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // With en low every register except done keeps its value, stretching the window.
         if (en) begin
            if (w_last)
               r_done <= 1'b1;
            if (w_accept) begin
               r_y       <= OUT_W'(1) << code;
               r_y_valid <= 1'b1;
               r_cnt     <= CNT_W'(HOLD - 1);
               r_state   <= S_HOLD;
            end else if (r_state == S_HOLD) begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_y       <= '0;
                  r_y_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
         end
      end
   end

   assign in_ready    = w_ready;
   assign y           = r_y;
   assign y_valid     = r_y_valid;
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_decoder_hold.sv
// Directed bench for decoder_hold: HOLD=4 instance for most scenarios,
// HOLD=1 instance for the continuous-stream case.
module tb_decoder_hold;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, in_valid;
   logic [1:0] code;
   logic       in_ready, y_valid, done, dbg_state;
   logic [3:0] y;

   logic       en1, in_valid1;
   logic [1:0] code1;
   logic       in_ready1, y_valid1, done1, dbg_state1;
   logic [3:0] y1;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   decoder_hold #(.IN_LEN(2), .HOLD(4), .CNT_W(8)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .code(code), .in_valid(in_valid),
      .in_ready(in_ready), .y(y), .y_valid(y_valid), .done(done),
      .o_dbg_state(dbg_state)
   );

   decoder_hold #(.IN_LEN(2), .HOLD(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .en(en1), .code(code1), .in_valid(in_valid1),
      .in_ready(in_ready1), .y(y1), .y_valid(y_valid1), .done(done1),
      .o_dbg_state(dbg_state1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Lands 2 time units after the next rising edge; inputs are driven and outputs checked here.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] v;
      rst = 1'b1; en = 1'b1; in_valid = 1'b0; code = '0;
      en1 = 1'b1; in_valid1 = 1'b0; code1 = '0;

      // reset state
      #2;
      check("rst_y", y, 4'b0000);
      check("rst_yv", y_valid, 0);
      check("rst_done", done, 0);
      check("rst_ready", in_ready, 0);
      check("rst_state", dbg_state, 0);
      check("rst_ready1", in_ready1, 0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      check("post_rst_ready", in_ready, 1);

      // single code 2'b10: four cycles of 0100, done in the fifth
      next_cycle();
      code = 2'd2; in_valid = 1'b1;
      #1;
      check("t1_ready_idle", in_ready, 1);
      next_cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("t1_y", y, 4'b0100);
         check("t1_yv", y_valid, 1);
         check("t1_done", done, 0);
         check("t1_ready", in_ready, (k == 3));
         check("t1_state", dbg_state, 1);
         next_cycle();
      end
      check("t1_y_end", y, 4'b0000);
      check("t1_yv_end", y_valid, 0);
      check("t1_done_end", done, 1);
      check("t1_state_end", dbg_state, 0);
      next_cycle();
      check("t1_done_clr", done, 0);

      // back-to-back sweep 0..3, no gap cycles
      for (int c = 0; c < 4; c++) begin
         v = 4'b0001 << c;
         for (int k = 0; k < 4; k++) exp_q.push_back(v);
      end
      exp_q.push_back(4'b0000);
      code = 2'd0; in_valid = 1'b1;
      next_cycle();
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) begin
            v = exp_q.pop_front();
            check("sw_y", y, v);
            check("sw_yv", y_valid, 1);
            check("sw_done", done, (c > 0 && k == 0));
            check("sw_ready", in_ready, (k == 3));
            if (k == 3) begin
               if (c < 3) code = 2'(c + 1);
               else in_valid = 1'b0;
            end
            next_cycle();
         end
      end
      v = exp_q.pop_front();
      check("sw_y_end", y, v);
      check("sw_done_end", done, 1);
      next_cycle();
      check("sw_done_clr", done, 0);

      // code 2'b11 with a 3-cycle enable pause: seven cycles high, done delayed
      code = 2'd3; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         en = !(k >= 2 && k <= 4);
         #1;
         check("en_y", y, 4'b1000);
         check("en_yv", y_valid, 1);
         check("en_done", done, 0);
         check("en_ready", in_ready, (k == 7));
         next_cycle();
      end
      check("en_y_end", y, 4'b0000);
      check("en_done_end", done, 1);
      next_cycle();
      check("en_done_clr", done, 0);

      // in_valid pulsed mid-window is ignored
      code = 2'd0; in_valid = 1'b1;
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin
            code = 2'd3; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check("ign_ready", in_ready, (k == 3));
         check("ign_y", y, 4'b0001);
         next_cycle();
      end
      check("ign_y_end", y, 4'b0000);
      check("ign_done_end", done, 1);
      next_cycle();

      // async reset on the 2nd hold cycle of code 2'b01
      code = 2'd1; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      check("rs_y_c1", y, 4'b0010);
      next_cycle();
      check("rs_y_c2", y, 4'b0010);
      rst = 1'b1;
      #1;
      check("rs_y_async", y, 4'b0000);
      check("rs_yv_async", y_valid, 0);
      check("rs_ready_async", in_ready, 0);
      check("rs_state_async", dbg_state, 0);
      next_cycle();
      check("rs_done_a", done, 0);
      next_cycle();
      check("rs_done_b", done, 0);
      rst = 1'b0;
      next_cycle();
      check("rs_y_idle", y, 4'b0000);
      check("rs_done_idle", done, 0);
      check("rs_ready_idle", in_ready, 1);
      code = 2'd1; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("rs2_y", y, 4'b0010);
         check("rs2_done", done, 0);
         next_cycle();
      end
      check("rs2_y_end", y, 4'b0000);
      check("rs2_done_end", done, 1);

      // HOLD=1 stream: y changes every cycle, done continuous from the 2nd cycle
      code1 = 2'd0; in_valid1 = 1'b1;
      #1;
      check("h1_ready_idle", in_ready1, 1);
      next_cycle();
      check("h1_y0", y1, 4'b0001);
      check("h1_done0", done1, 0);
      check("h1_ready0", in_ready1, 1);
      for (int c = 1; c < 4; c++) begin
         code1 = 2'(c);
         next_cycle();
         v = 4'b0001 << c;
         check("h1_y", y1, v);
         check("h1_yv", y_valid1, 1);
         check("h1_done", done1, 1);
         check("h1_ready", in_ready1, 1);
      end
      in_valid1 = 1'b0;
      next_cycle();
      check("h1_y_end", y1, 4'b0000);
      check("h1_yv_end", y_valid1, 0);
      check("h1_done_end", done1, 1);
      next_cycle();
      check("h1_done_clr", done1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
